// File: rtl/if_id_skid_buffer_if.sv
// Fetch/Decode handshake bundle for the IF/ID elastic buffer.
// Valid/ready rule for both sides: a transfer happens on a rising clock edge
// only when the producer's valid and the consumer's ready are both high in
// that cycle. The producer holds its payload while valid is high and no
// transfer has happened. Flush and stall are side-band signals on the buffer
// and also gate transfers.
interface if_id_skid_buffer_if;
    // Fetch side
    logic        i_vld;
    logic [31:0] i_pc;
    logic [31:0] i_instr;
    logic        i_prediction;
    logic        o_rdy;
    // Decode side
    logic        o_vld;
    logic [31:0] o_pc;
    logic [31:0] o_instr;
    logic        o_prediction;
    logic        o_misalign;
    logic        i_dec_rdy;

    // Buffer side of the bundle
    modport slave (
        input  i_vld, i_pc, i_instr, i_prediction, i_dec_rdy,
        output o_rdy, o_vld, o_pc, o_instr, o_prediction, o_misalign
    );

    // Environment side (Fetch producer + Decode consumer)
    modport master (
        output i_vld, i_pc, i_instr, i_prediction, i_dec_rdy,
        input  o_rdy, o_vld, o_pc, o_instr, o_prediction, o_misalign
    );
endinterface

// File: rtl/if_id_skid_buffer.sv
// IF/ID elastic buffer: a small circular FIFO between Fetch and Decode.
// All outputs, including o_rdy, come from registers only, so Decode's stall
// and ready signals never reach Fetch combinationally. A flush empties the
// buffer in one edge and drops whatever Fetch offers in that cycle.
module if_id_skid_buffer #(
    parameter int          DEPTH = 2,
    parameter logic [31:0] NOP   = 32'h00000013,
    localparam int         PTR_W = $clog2(DEPTH),
    localparam int         CNT_W = PTR_W + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    if_id_skid_buffer_if.slave   bus,
    input  logic                 i_stall,
    input  logic                 i_flush,
    output logic [CNT_W-1:0]     o_count
);

    typedef struct packed {
        logic        misalign;
        logic        prediction;
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           wr_entry_d;
    entry_t           head;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic             rdy;
    logic             vld;
    logic             push;
    logic             pop;

    // Handshake qualifiers and next-state for pointers/occupancy
    always_comb begin
        rdy        = (count_q < CNT_W'(DEPTH));
        vld        = (count_q != '0);
        push       = bus.i_vld & rdy & ~i_flush;
        pop        = vld & bus.i_dec_rdy & ~i_stall & ~i_flush;

        wr_entry_d = '{misalign:   (bus.i_pc[1:0] != 2'b00),
                       prediction: bus.i_prediction,
                       instr:      bus.i_instr,
                       pc:         bus.i_pc};

        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (i_flush) begin
            // Drop everything: read pointer catches up with the write pointer.
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care while unoccupied, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry_d;
        end
    end

    // Head presentation: stored entry when occupied, bubble (NOP) otherwise
    always_comb begin
        head = mem_q[rd_ptr_q];
        if (vld) begin
            bus.o_pc         = head.pc;
            bus.o_instr      = head.instr;
            bus.o_prediction = head.prediction;
            bus.o_misalign   = head.misalign;
        end else begin
            bus.o_pc         = 32'h0;
            bus.o_instr      = NOP;
            bus.o_prediction = 1'b0;
            bus.o_misalign   = 1'b0;
        end
        bus.o_vld = vld;
        bus.o_rdy = rdy;
        o_count   = count_q;
    end

endmodule

// File: tb/tb_if_id_skid_buffer.sv
// Bench for if_id_skid_buffer: directed scenarios plus a long random run,
// all compared against a queue model of an ordered bounded buffer.
module tb_if_id_skid_buffer;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic       clk;
  logic       rst_n;
  logic       i_stall;
  logic       i_flush;
  logic [1:0] o_count;

  if_id_skid_buffer_if bus ();

  if_id_skid_buffer #(.DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .i_stall (i_stall),
    .i_flush (i_flush),
    .o_count (o_count)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  // model: ordered entries {prediction, instr, pc}, oldest at index 0
  logic [64:0] exp_q[$];

  // observed vs expected full status vector
  logic [69:0] obs_v;
  logic [69:0] exp_v;

  function automatic logic [69:0] model_status();
    logic [64:0] h;
    logic [1:0]  cnt;
    cnt = 2'(exp_q.size());
    if (exp_q.size() != 0) h = exp_q[0];
    else h = {1'b0, NOP, 32'h0};
    return {exp_q.size() != 0, exp_q.size() < DEPTH, cnt, h[64],
            h[1:0] != 2'b00, h[63:32], h[31:0]};
  endfunction

  function automatic logic [69:0] dut_status();
    return {bus.o_vld, bus.o_rdy, o_count, bus.o_prediction, bus.o_misalign,
            bus.o_instr, bus.o_pc};
  endfunction

  // driver: set inputs (called at negedge)
  task automatic drive(input logic vld, input logic [31:0] pc, input logic [31:0] instr,
                       input logic pred, input logic dec_rdy, input logic stall,
                       input logic flush);
    bus.i_vld        = vld;
    bus.i_pc         = pc;
    bus.i_instr      = instr;
    bus.i_prediction = pred;
    bus.i_dec_rdy    = dec_rdy;
    i_stall          = stall;
    i_flush          = flush;
  endtask

  // advance one clock; model updated from the buffer's transfer rules
  task automatic tick();
    logic push, pop;
    @(posedge clk);
    push = bus.i_vld && (exp_q.size() < DEPTH) && !i_flush;
    pop  = (exp_q.size() != 0) && bus.i_dec_rdy && !i_stall && !i_flush;
    if (i_flush) begin
      exp_q.delete();
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (push) exp_q.push_back({bus.i_prediction, bus.i_instr, bus.i_pc});
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.delete();
    @(negedge clk);
    checks++;
    if (bus.o_vld !== 1'b0 || bus.o_instr !== NOP || o_count !== 2'd0 || bus.o_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_init got vld=%b instr=%h cnt=%0d pc=%h want vld=0 instr=%h cnt=0 pc=0",
               bus.o_vld, bus.o_instr, o_count, bus.o_pc, NOP);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.o_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_rdy got=%b want=1", bus.o_rdy);
    end
    // fill to two entries, then reset mid-stream
    drive(1'b1, 32'h40, ~32'h40, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h44, ~32'h44, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    checks++;
    if (o_count !== 2'd2) begin
      errors++;
      $display("FAIL reset_prefill_count got=%0d want=2", o_count);
    end
    drive(1'b1, 32'h48, ~32'h48, 1'b0, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if (bus.o_vld !== 1'b0 || bus.o_instr !== NOP || o_count !== 2'd0) begin
      errors++;
      $display("FAIL reset_async got vld=%b instr=%h cnt=%0d want vld=0 instr=%h cnt=0",
               bus.o_vld, bus.o_instr, o_count, NOP);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.o_rdy !== 1'b1 || bus.o_vld !== 1'b0 || o_count !== 2'd0 || bus.o_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_release got rdy=%b vld=%b cnt=%0d pc=%h want rdy=1 vld=0 cnt=0 pc=0",
               bus.o_rdy, bus.o_vld, o_count, bus.o_pc);
    end
  endtask

  task automatic test_streaming();
    logic [31:0] pcs [3];
    pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, pcs[i], ~pcs[i], 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      checks++;
      if (bus.o_vld !== 1'b1 || bus.o_pc !== pcs[i] || bus.o_instr !== ~pcs[i] || o_count !== 2'd1) begin
        errors++;
        $display("FAIL stream_%0d got vld=%b pc=%h instr=%h cnt=%0d want vld=1 pc=%h instr=%h cnt=1",
                 i, bus.o_vld, bus.o_pc, bus.o_instr, o_count, pcs[i], ~pcs[i]);
      end
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    checks++;
    if (bus.o_vld !== 1'b0 || o_count !== 2'd0) begin
      errors++;
      $display("FAIL stream_drain got vld=%b cnt=%0d want vld=0 cnt=0", bus.o_vld, o_count);
    end
  endtask

  task automatic test_stall_fill();
    drive(1'b1, 32'h10, ~32'h10, 1'b0, 1'b1, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h14, ~32'h14, 1'b0, 1'b1, 1'b1, 1'b0); tick();
    checks++;
    if (o_count !== 2'd2 || bus.o_rdy !== 1'b0 || bus.o_pc !== 32'h10) begin
      errors++;
      $display("FAIL stall_full got cnt=%0d rdy=%b pc=%h want cnt=2 rdy=0 pc=10",
               o_count, bus.o_rdy, bus.o_pc);
    end
    // 0x18 offered while full and stalled: held off, head held
    drive(1'b1, 32'h18, ~32'h18, 1'b0, 1'b1, 1'b1, 1'b0); tick();
    checks++;
    if (o_count !== 2'd2 || bus.o_pc !== 32'h10 || bus.o_instr !== ~32'h10) begin
      errors++;
      $display("FAIL stall_hold got cnt=%0d pc=%h instr=%h want cnt=2 pc=10 instr=%h",
               o_count, bus.o_pc, bus.o_instr, ~32'h10);
    end
    // release: 0x10 pops, 0x18 still blocked by full-at-edge
    drive(1'b1, 32'h18, ~32'h18, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    checks++;
    if (o_count !== 2'd1 || bus.o_pc !== 32'h14) begin
      errors++;
      $display("FAIL stall_rel1 got cnt=%0d pc=%h want cnt=1 pc=14", o_count, bus.o_pc);
    end
    drive(1'b1, 32'h18, ~32'h18, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    checks++;
    if (o_count !== 2'd1 || bus.o_pc !== 32'h18) begin
      errors++;
      $display("FAIL stall_rel2 got cnt=%0d pc=%h want cnt=1 pc=18", o_count, bus.o_pc);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    checks++;
    if (o_count !== 2'd0 || bus.o_vld !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain got cnt=%0d vld=%b want cnt=0 vld=0", o_count, bus.o_vld);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h30, ~32'h30, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h34, ~32'h34, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h20, ~32'h20, 1'b0, 1'b1, 1'b1, 1'b1); tick();
    checks++;
    if (bus.o_vld !== 1'b0 || o_count !== 2'd0 || bus.o_rdy !== 1'b1 || bus.o_instr !== NOP) begin
      errors++;
      $display("FAIL flush_empty got vld=%b cnt=%0d rdy=%b instr=%h want vld=0 cnt=0 rdy=1 instr=%h",
               bus.o_vld, o_count, bus.o_rdy, bus.o_instr, NOP);
    end
    // 0x20 must never surface; a later push must appear alone at the head
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
      checks++;
      if (bus.o_pc === 32'h20 || bus.o_vld !== 1'b0) begin
        errors++;
        $display("FAIL flush_ghost_%0d got vld=%b pc=%h want vld=0 pc!=20", i, bus.o_vld, bus.o_pc);
      end
    end
    drive(1'b1, 32'h24, ~32'h24, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    checks++;
    if (bus.o_pc !== 32'h24 || o_count !== 2'd1) begin
      errors++;
      $display("FAIL flush_after got pc=%h cnt=%0d want pc=24 cnt=1", bus.o_pc, o_count);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
  endtask

  task automatic test_misalign_pred();
    drive(1'b1, 32'h102, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h104, 32'h0000_1111, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    checks++;
    if (bus.o_misalign !== 1'b1 || bus.o_prediction !== 1'b1 || bus.o_pc !== 32'h102
        || bus.o_instr !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL misalign_head got mis=%b pred=%b pc=%h instr=%h want mis=1 pred=1 pc=102 instr=deadbeef",
               bus.o_misalign, bus.o_prediction, bus.o_pc, bus.o_instr);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    checks++;
    if (bus.o_misalign !== 1'b0 || bus.o_prediction !== 1'b0 || bus.o_pc !== 32'h104) begin
      errors++;
      $display("FAIL misalign_next got mis=%b pred=%b pc=%h want mis=0 pred=0 pc=104",
               bus.o_misalign, bus.o_prediction, bus.o_pc);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
  endtask

  task automatic test_random();
    logic [31:0] pc;
    int          shown;
    pc    = 32'h1000;
    shown = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      obs_v = dut_status();
      exp_v = model_status();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        if (shown < 20) begin
          shown++;
          $display("FAIL random_cyc%0d got=%h want=%h", cyc, obs_v, exp_v);
        end
      end
      if (bus.i_vld && exp_q.size() < DEPTH && !i_flush) begin
        pc = pc + 32'd4;
        if ($urandom_range(0, 7) == 0) pc[1:0] = 2'($urandom_range(1, 3));
        else pc[1:0] = 2'b00;
      end
      if (bus.i_vld && !(exp_q.size() < DEPTH) && !i_flush && $urandom_range(0, 1) == 0) begin
        // keep offering the same fetch while held off
        drive(1'b1, bus.i_pc, bus.i_instr, bus.i_prediction,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 30) == 0));
      end else begin
        drive(1'($urandom_range(0, 9) < 7), pc, $urandom, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
              1'($urandom_range(0, 30) == 0));
      end
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); tick();
    checks++;
    if (bus.o_vld !== 1'b0 || o_count !== 2'd0) begin
      errors++;
      $display("FAIL random_drain got vld=%b cnt=%0d want vld=0 cnt=0", bus.o_vld, o_count);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall_fill();
    test_flush();
    test_misalign_pred();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
